// File: rtl/mult_output_accumulator_if.sv
// Handshake bundle for the multiplier output accumulator.
// The slave modport is the accumulator's view; the master modport is the
// producer/consumer side that drives samples and takes frame results.
interface mult_output_accumulator_if #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  z_in;
  logic [5:0]       round_shift;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;
  logic             dout_sat;

  modport slave (
    input  in_valid,
    output in_ready,
    input  z_in,
    input  round_shift,
    output out_valid,
    input  out_ready,
    output dout,
    output dout_sat
  );

  modport master (
    output in_valid,
    input  in_ready,
    output z_in,
    output round_shift,
    input  out_valid,
    output out_ready,
    input  dout,
    input  dout_sat
  );
endinterface

// File: rtl/mult_output_accumulator.sv
// Frame accumulator for the unsigned shift-add multiplier datapath.
// Sums FRAME_LEN unsigned samples, then applies a round-half-up right shift
// and presents one OUT_W-bit result per frame on a valid/ready output.
// Build option: define MULT_ACC_SAT_EN to clip results that do not fit in
// OUT_W bits (dout_sat flags the clip); otherwise the result wraps and
// dout_sat is tied low.
module mult_output_accumulator #(
  parameter int IN_W      = 38,
  parameter int ACC_W     = 44,
  parameter int OUT_W     = 20,
  parameter int FRAME_LEN = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  mult_output_accumulator_if.slave     bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [5:0]          shift_q;
  logic                out_valid_q;
  logic [OUT_W-1:0]    dout_q;

  logic [ACC_W-1:0]    z_ext_d;
  logic [ACC_W:0]      r_d;
  logic [OUT_W-1:0]    dout_d;

  // Round-half-up right shift of the frame sum, evaluated one bit wider than
  // the accumulator so the rounding bias cannot overflow. Shifts beyond the
  // accumulator width leave nothing, so the result is forced to zero.
  function automatic logic [ACC_W:0] round_fn(input logic [ACC_W-1:0] acc,
                                              input logic [5:0]       sh);
    logic [ACC_W:0] bias;
    logic [ACC_W:0] sum;
    if (32'(sh) > ACC_W) begin
      return '0;
    end
    bias = (sh == 6'd0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (sh - 6'd1));
    sum  = {1'b0, acc} + bias;
    return sum >> sh;
  endfunction

`ifdef MULT_ACC_SAT_EN
  logic                dout_sat_q;
  logic                sat_d;

  // Unsigned clip to OUT_W bits; returns {clipped, value}.
  function automatic logic [OUT_W:0] sat_fn(input logic [ACC_W:0] r);
    if (|r[ACC_W:OUT_W]) begin
      return {1'b1, {OUT_W{1'b1}}};
    end
    return {1'b0, r[OUT_W-1:0]};
  endfunction
`endif

  // Zero-extend the sample and form the scaled frame result from the held sum.
  always_comb begin
    z_ext_d = {{(ACC_W-IN_W){1'b0}}, bus.z_in};
    r_d     = round_fn(acc_q, shift_q);
  end

`ifdef MULT_ACC_SAT_EN
  // Clip the rounded sum into the output width.
  always_comb begin
    {sat_d, dout_d} = sat_fn(r_d);
  end
`else
  // Plain truncation: the high bits of the rounded sum are simply dropped.
  logic unused_r_hi;
  always_comb begin
    dout_d      = r_d[OUT_W-1:0];
    unused_r_hi = ^r_d[ACC_W:OUT_W];
  end
`endif

  // Frame FSM: accumulate FRAME_LEN samples, round for one cycle, hold the
  // result until the consumer takes it. All outputs except in_ready are
  // registered here; in_ready depends on state only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
`ifdef MULT_ACC_SAT_EN
      dout_sat_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            // First sample of a frame loads the sum and fixes the shift
            // for the whole frame.
            if (cnt_q == '0) begin
              acc_q   <= z_ext_d;
              shift_q <= bus.round_shift;
            end else begin
              acc_q   <= acc_q + z_ext_d;
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          dout_q      <= dout_d;
`ifdef MULT_ACC_SAT_EN
          dout_sat_q  <= sat_d;
`endif
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
`ifdef MULT_ACC_SAT_EN
  assign bus.dout_sat  = dout_sat_q;
`else
  assign bus.dout_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_output_accumulator.sv
// Directed bench for mult_output_accumulator: a table of whole-frame vectors
// plus hand-written reset and backpressure sequences.
module tb_mult_output_accumulator;

  localparam int IN_W  = 38;
  localparam int OUT_W = 20;
  localparam logic [37:0] ZMAX = 38'h3FFFFFFFFF;

`ifdef MULT_ACC_SAT_EN
  localparam logic [19:0] SAT_D = 20'd1048575;
  localparam logic        SAT_S = 1'b1;
`else
  localparam logic [19:0] SAT_D = 20'd1048568;
  localparam logic        SAT_S = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mult_output_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  mult_output_accumulator #(
    .IN_W(IN_W), .ACC_W(44), .OUT_W(OUT_W), .FRAME_LEN(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [37:0] z;
    logic [5:0]  sh0;
    logic [5:0]  sh1;
    logic [19:0] exp_d;
    logic        exp_s;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Feed n samples starting at a negedge; round_shift is sh0 for the first
  // sample and sh1 afterwards. Returns at the negedge after the last accept.
  task automatic feed(input string name, input logic [37:0] z, input int n,
                      input logic [5:0] sh0, input logic [5:0] sh1);
    for (int i = 0; i < n; i++) begin
      check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.round_shift = (i == 0) ? sh0 : sh1;
      bus.z_in        = z;
      bus.in_valid    = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Called at the negedge right after the last accept edge: checks the
  // two-edge latency, the result, then takes it and checks the return to ACCUM.
  task automatic collect(input string name, input logic [19:0] exp_d, input logic exp_s);
    check({name, " round out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, " round in_ready"}, 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, " dout"}, 64'(bus.dout), 64'(exp_d));
    check({name, " dout_sat"}, 64'(bus.dout_sat), 64'(exp_s));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " done out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, " done in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{"directed", 38'd4606, 6'd0,  6'd0,  20'd36848, 1'b0};
    vecs[1] = '{"round",    38'd5,    6'd4,  6'd4,  20'd3,     1'b0};
    vecs[2] = '{"shiftlat", 38'd5,    6'd3,  6'd0,  20'd5,     1'b0};
    vecs[3] = '{"sat",      ZMAX,     6'd0,  6'd0,  SAT_D,     SAT_S};
    vecs[4] = '{"sh41",     ZMAX,     6'd41, 6'd41, 20'd1,     1'b0};
    vecs[5] = '{"sh63",     ZMAX,     6'd63, 6'd63, 20'd0,     1'b0};
    vecs[6] = '{"odd",      38'd7,    6'd1,  6'd1,  20'd28,    1'b0};

    bus.in_valid    = 1'b0;
    bus.z_in        = '0;
    bus.round_shift = '0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;

    // Reset takes effect before any clock edge.
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset dout", 64'(bus.dout), 64'd0);
    check("reset dout_sat", 64'(bus.dout_sat), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      feed(vecs[v].name, vecs[v].z, 8, vecs[v].sh0, vecs[v].sh1);
      collect(vecs[v].name, vecs[v].exp_d, vecs[v].exp_s);
    end

    // Backpressure: result held with in_valid high, nothing consumed.
    feed("bp", 38'd2, 8, 6'd0, 6'd0);
    @(negedge clk);
    bus.z_in     = 38'd100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold out_valid", 64'(bus.out_valid), 64'd1);
      check("bp hold dout", 64'(bus.dout), 64'd16);
      check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    // Release with in_valid still high: eight accepts follow the release edge.
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("bp next in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    collect("bp next", 20'd800, 1'b0);

    // Reset mid-frame after three accepts, then a clean frame of ones.
    feed("mid", 38'd7, 3, 6'd2, 6'd2);
    #2 reset = 1'b1;
    #1;
    check("mid reset in_ready", 64'(bus.in_ready), 64'd1);
    check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    feed("post reset", 38'd1, 8, 6'd0, 6'd0);
    collect("post reset", 20'd8, 1'b0);

    // Reset while a result is pending drops it immediately.
    feed("hold rst", ZMAX, 8, 6'd0, 6'd0);
    @(negedge clk);
    check("hold rst pre out_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("hold rst out_valid", 64'(bus.out_valid), 64'd0);
    check("hold rst dout", 64'(bus.dout), 64'd0);
    check("hold rst dout_sat", 64'(bus.dout_sat), 64'd0);
    check("hold rst in_ready", 64'(bus.in_ready), 64'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    feed("after hold rst", 38'd3, 8, 6'd1, 6'd1);
    collect("after hold rst", 20'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_output_accumulator.md
# mult_output_accumulator

Frame accumulator downstream of the shift-add multiplier stage. Consumes the unsigned 38-bit `z_out` sum one sample per handshake and accumulates `FRAME_LEN` samples. It then applies round-half-up right shift and optional unsigned saturation, and presents one 20-bit result per frame on a valid/ready output. It is the output decimation/scaling stage of the unsigned multiplier datapath.

## Interface
- `IN_W`, 38, width of incoming sample (`z_out` width).
- `ACC_W`, 44, accumulator width. Requires `FRAME_LEN <= 2**(ACC_W-IN_W)`, so the accumulator never wraps.
- `OUT_W`, 20, result width.
- `FRAME_LEN`, 8, samples per frame, range 1..64.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: sample qualifier.
- `in_ready` out 1: stage accepts a sample this cycle.
- `z_in` in IN_W: unsigned sample from the shift-add stage.
- `round_shift` in 6: right-shift amount, 0..63.
- `out_valid` out 1: `dout` holds a frame result.
- `out_ready` in 1: downstream accepts the result.
- `dout` out OUT_W: scaled frame result.
- `dout_sat` out 1: result was clipped. Qualified by `out_valid`.

## Operation
- Three-state FSM: ACCUM, ROUND, HOLD. Reset state is ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On `in_valid && in_ready`: `acc <= acc + z_in` (zero-extended), `cnt <= cnt+1`.
  - The first accepted sample of a frame loads `acc <= z_in`, not an add, and latches `round_shift` into `shift_q`. Changes to `round_shift` mid-frame are ignored.
  - When the accepted sample is number `FRAME_LEN`, go to ROUND.
- **ROUND** (one cycle)
  - `in_ready`=0.
  - `r = (acc + (shift_q ? 1<<(shift_q-1) : 0)) >> shift_q`, computed in ACC_W+1 bits.
  - If `shift_q > ACC_W`, `r` = 0.
  - Register `dout`/`dout_sat` from `r`, set `out_valid`=1, go to HOLD.
- **HOLD**
  - `in_ready`=0. `in_valid` is ignored and no sample is consumed.
  - `dout`, `dout_sat` and `out_valid` stay stable until `out_ready`=1.
  - On the `out_valid && out_ready` edge: `out_valid`<=0, `cnt`<=0, go to ACCUM.
- Saturation behaviour is set by the macro in Configuration.
- `FRAME_LEN`=1: every accepted sample goes straight to ROUND.
- Reset mid-operation, in any state: `acc`, `cnt`, `shift_q` cleared, FSM to ACCUM, any pending result dropped.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `dout`=0, `dout_sat`=0, `acc`=0, `cnt`=0, `shift_q`=0.
- Last sample accepted at edge k. ROUND during cycle k..k+1. `out_valid`=1 after edge k+1 (latency 2 edges from last accept to result visible).
- Output accepted at edge m. `in_ready`=1 after edge m, so the earliest next-frame sample is accepted at edge m+1.
- No combinational path from `out_ready` or `in_valid` to any output. `in_ready` is a pure function of FSM state.
- Minimum frame period is `FRAME_LEN`+2 cycles with `out_ready` held high.

## Configuration
- `MULT_ACC_SAT_EN` defined:
  - If `r >= 2**OUT_W`, `dout` = `2**OUT_W-1` and `dout_sat`=1.
  - Otherwise `dout` = `r[OUT_W-1:0]` and `dout_sat`=0.
- Not defined:
  - `dout` = `r[OUT_W-1:0]` (truncation, wrap).
  - `dout_sat` tied to 0.
  - No comparator logic is synthesized.

## Test plan
- Reset idle: assert `reset` asynchronously mid-cycle. Required: `out_valid`=0, `dout`=0, `in_ready`=1 immediately, without waiting for a clock edge.
- Directed sum: 8 samples `z_in`=4606 (a=255, b=1, shift 1), `round_shift`=0. Required: `dout`=36848, `dout_sat`=0, `out_valid` 2 edges after the 8th accept.
- Rounding: 8 samples of 5, `round_shift`=4. Required: `dout`=3 (40/16=2.5 rounds up).
- Repeat rounding: same frame with `round_shift`=3 changed to 0 after sample 1. Required: `dout`=5, since `shift_q` stays 3.
- Saturation: 8 samples of `38'h3FFFFFFFFF`, `round_shift`=0.
  - With `MULT_ACC_SAT_EN`: `dout`=1048575, `dout_sat`=1.
  - Without it: `dout`=1048568, `dout_sat`=0.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1. Required: `dout` stable, `in_ready`=0, no sample consumed; the next frame starts only after the release edge.
  - Then accept 3 samples, pulse `reset`, then send 8 samples of 1. Required: `dout`=8.
